// File: rtl/fx_pkg.sv
// Shared types and constants for the pedal effect sequencer.
package fx_pkg;

  typedef enum logic [1:0] {
    MODE_BYPASS = 2'd0,
    MODE_CLIP   = 2'd1,
    MODE_REVERB = 2'd2,
    MODE_BOTH   = 2'd3
  } mode_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    EMIT  = 2'd3
  } seq_state_t;

  // Output value used while muting; midscale of a 12-bit unsigned sample.
  localparam int unsigned MIDSCALE = 2048;

endpackage

// File: rtl/fx_sequencer_switch_debounce.sv
// Footswitch conditioning: 2-flop synchronizer, stability counter, press pulse.
module switch_debounce #(
  parameter int unsigned DB_CYCLES = 65536
) (
  input  logic clk,
  input  logic reset,
  input  logic sw_in,
  output logic press
);

  localparam int unsigned CW = $clog2(DB_CYCLES + 1);

  logic          sync1_q, sync2_q;
  logic          level_q;
  logic          press_q;
  logic [CW-1:0] cnt_q;
  logic          cnt_done;

  assign cnt_done = (cnt_q == CW'(DB_CYCLES - 1));
  assign press    = press_q;

  // Bring the raw switch into the clock domain.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
    end else begin
      sync1_q <= sw_in;
      sync2_q <= sync1_q;
    end
  end

  // Flip the debounced level after DB_CYCLES consecutive clocks at the new level;
  // a rising flip produces a one-cycle press pulse.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q   <= '0;
      level_q <= 1'b0;
      press_q <= 1'b0;
    end else begin
      press_q <= 1'b0;
      if (sync2_q != level_q) begin
        if (cnt_done) begin
          cnt_q   <= '0;
          level_q <= sync2_q;
          press_q <= sync2_q;
        end else begin
          cnt_q <= cnt_q + 1'b1;
        end
      end else begin
        cnt_q <= '0;
      end
    end
  end

endmodule

// File: rtl/fx_sequencer.sv
// Per-sample controller: mode cycling, chain handshake, timeout fallback and mute.
module fx_sequencer #(
  parameter int unsigned W            = 12,
  parameter int unsigned DB_CYCLES    = 65536,
  parameter int unsigned MUTE_SAMPLES = 16,
  parameter int unsigned TIMEOUT      = 1024,
  parameter int unsigned MIDSCALE     = fx_pkg::MIDSCALE
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         sw_in,
  input  logic         adc_valid,
  input  logic [W-1:0] adc_data,
  output logic         st_valid,
  output logic [W-1:0] st_data,
  input  logic         st_done,
  input  logic [W-1:0] st_result,
  output logic         clip_en,
  output logic         reverb_en,
  output logic         dac_valid,
  output logic [W-1:0] dac_data,
  output logic [1:0]   mode,
  output logic         overrun,
  output logic         timeout_err
);

  import fx_pkg::*;

  localparam int unsigned WCW = $clog2(TIMEOUT);
  localparam int unsigned MCW = $clog2(MUTE_SAMPLES + 1);

  seq_state_t     state_q, state_d;
  mode_t          mode_q;
  logic [1:0]     mode_inc;
  logic           clip_q, reverb_q;
  logic [MCW-1:0] mute_q;
  logic [W-1:0]   sample_q, result_q, dac_data_q;
  logic [WCW-1:0] wait_cnt_q;
  logic           dac_valid_q, overrun_q, tmo_q;
  logic           press, muted;
  logic           latch_adc, latch_done, take_tmo, emit;

  switch_debounce #(
    .DB_CYCLES(DB_CYCLES)
  ) u_debounce (
    .clk  (clk),
    .reset(reset),
    .sw_in(sw_in),
    .press(press)
  );

  assign mode_inc = mode_q + 2'd1;
  // A press coinciding with an emit mutes that sample too.
  assign muted    = (mute_q != '0) || press;

  // Sequencer state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next-state and per-state control strobes.
  always_comb begin
    state_d    = state_q;
    latch_adc  = 1'b0;
    latch_done = 1'b0;
    take_tmo   = 1'b0;
    emit       = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (adc_valid) begin
          latch_adc = 1'b1;
          state_d   = (mode_q == MODE_BYPASS) ? EMIT : ISSUE;
        end
      end
      ISSUE: state_d = WAIT;
      WAIT: begin
        // st_done takes priority over a simultaneous timeout.
        if (st_done) begin
          latch_done = 1'b1;
          state_d    = EMIT;
        end else if (wait_cnt_q == WCW'(TIMEOUT - 1)) begin
          take_tmo = 1'b1;
          state_d  = EMIT;
        end
      end
      EMIT: begin
        emit    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Sample/result capture, wait counter, DAC output and sticky flags.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sample_q    <= '0;
      result_q    <= '0;
      wait_cnt_q  <= '0;
      dac_valid_q <= 1'b0;
      dac_data_q  <= W'(MIDSCALE);
      overrun_q   <= 1'b0;
      tmo_q       <= 1'b0;
    end else begin
      dac_valid_q <= emit;
      if (latch_adc) begin
        sample_q <= adc_data;
        result_q <= adc_data;
      end
      if (state_q == ISSUE)     wait_cnt_q <= '0;
      else if (state_q == WAIT) wait_cnt_q <= wait_cnt_q + 1'b1;
      if (latch_done) result_q <= st_result;
      if (take_tmo) begin
        result_q <= sample_q;
        tmo_q    <= 1'b1;
      end
      if (emit) dac_data_q <= muted ? W'(MIDSCALE) : result_q;
      if (adc_valid && (state_q != IDLE)) overrun_q <= 1'b1;
    end
  end

  // Mode cycling on press; mute counter reloads on press, counts down per emitted sample.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mode_q   <= MODE_BYPASS;
      clip_q   <= 1'b0;
      reverb_q <= 1'b0;
      mute_q   <= '0;
    end else if (press) begin
      mode_q   <= mode_t'(mode_inc);
      clip_q   <= mode_inc[0];
      reverb_q <= mode_inc[1];
      mute_q   <= MCW'(MUTE_SAMPLES);
    end else if (emit && (mute_q != '0)) begin
      mute_q <= mute_q - 1'b1;
    end
  end

  assign st_valid    = (state_q == ISSUE);
  assign st_data     = sample_q;
  assign clip_en     = clip_q;
  assign reverb_en   = reverb_q;
  assign dac_valid   = dac_valid_q;
  assign dac_data    = dac_data_q;
  assign mode        = mode_q;
  assign overrun     = overrun_q;
  assign timeout_err = tmo_q;

endmodule

// File: doc/fx_sequencer.md
Name: fx_sequencer

Overview:
Per-sample controller for the pedal effect datapath, between the ADC SPI front end and the IPS/DAC back end. It debounces the footswitch and cycles the effect mode. For each ADC sample it issues a one-sample request to the processing chain (clip/reverb), waits for the result and forwards it to the DAC. Every mode change is masked by a short midscale mute so switching does not click.

Parameters:
W, 12, sample width in bits
DB_CYCLES, 65536, clocks the switch must stay stable to register a change
MUTE_SAMPLES, 16, output samples forced to midscale after a mode change
TIMEOUT, 1024, maximum clocks to wait for st_done before falling back
MIDSCALE, 2048, mute output value (W bits)

Ports:
clk  in  1  system clock; single clock domain
reset  in  1  asynchronous, active-high reset
sw_in  in  1  raw footswitch, asynchronous, active-high when pressed
adc_valid  in  1  one-cycle strobe: new sample on adc_data
adc_data  in  W  ADC sample
st_valid  out  1  one-cycle request to processing chain
st_data  out  W  sample presented with st_valid
st_done  in  1  one-cycle strobe: chain result ready
st_result  in  W  chain result, valid with st_done
clip_en  out  1  hard-clip stage enable
reverb_en  out  1  reverb stage enable
dac_valid  out  1  one-cycle strobe to the DAC interface
dac_data  out  W  sample to the DAC
mode  out  2  current mode, for the LEDs
overrun  out  1  sticky flag: a sample was dropped while busy
timeout_err  out  1  sticky flag: the chain failed to answer within TIMEOUT

Behaviour:
- Reset values: all outputs 0, except dac_data = MIDSCALE. mode = 0, FSM = IDLE, mute counter = 0.
- Switch input: 2-flop synchronizer, then a counter. The debounced level changes only after DB_CYCLES consecutive clocks at the new level.
  - A rising edge of the debounced level is a press.
  - Releases are ignored.
- Mode encoding: 0 bypass, 1 clip, 2 reverb, 3 clip+reverb.
  - Each press increments mode modulo 4 (3 wraps to 0).
  - clip_en = mode[0]; reverb_en = mode[1]. Both are registered and update in the same cycle as mode.
- Mute on press:
  - The mute counter loads MUTE_SAMPLES.
  - While the counter is nonzero, each emitted sample has dac_data = MIDSCALE, and each emitted sample decrements the counter.
  - The chain still runs during mute so its state flushes.
  - A press during mute advances mode again and reloads the counter.
- FSM states: IDLE, ISSUE, WAIT, EMIT.
  - IDLE: on adc_valid, latch adc_data.
    - If mode == 0, go to EMIT.
    - Otherwise go to ISSUE.
  - ISSUE: st_valid = 1 for exactly one cycle with st_data = the latched sample. Clear the wait counter and go to WAIT.
  - WAIT: on st_done, latch st_result and go to EMIT. If the wait counter reaches TIMEOUT-1 without st_done:
    - set timeout_err;
    - emit the latched ADC sample (raw bypass);
    - go to EMIT.
  - EMIT: dac_valid = 1 for one cycle with dac_data = result, or MIDSCALE if muted. Return to IDLE.
  - dac_data holds its value between strobes.
- Latency from adc_valid to dac_valid:
  - bypass: exactly 2 clocks;
  - effect modes: 3 clocks plus the chain response time.
- Overrun: an adc_valid arriving in any state other than IDLE is dropped and sets overrun. The sample in flight is unaffected.
- st_done is ignored outside WAIT.
- If st_done and the timeout occur in the same cycle, st_done wins and no error is flagged.
- Mode change mid-sample: mode may change while the FSM is in WAIT. The in-flight sample completes, and the mute covers its output.
- Sticky flags clear only on reset.
- Asserting reset mid-operation immediately returns all state to reset values. st_valid and dac_valid drop in the same cycle.

Decomposition:
- Shared package fx_pkg:
  - typedef mode_t (2-bit enum: MODE_BYPASS, MODE_CLIP, MODE_REVERB, MODE_BOTH);
  - typedef seq_state_t (IDLE, ISSUE, WAIT, EMIT);
  - constant MIDSCALE.
- One sub-module, switch_debounce: synchronizer, stability counter and press-pulse output. Parameter DB_CYCLES.

Test Plan:
1. Reset, then adc_valid with adc_data = 12'd1500 in mode 0 -> dac_valid 2 clocks later with dac_data = 1500; st_valid never asserts.
2. One press (sw_in held 1 for > DB_CYCLES, DB_CYCLES set to 8 in the bench) -> mode = 1, clip_en = 1. The next 16 samples emit 2048; sample 17 emits st_result (0xABC returned 5 clocks after st_valid).
3. sw_in toggling every 3 clocks for 100 clocks -> mode unchanged. Four clean presses -> mode sequence 1, 2, 3, 0.
4. Mode 1, st_done withheld -> after TIMEOUT clocks timeout_err = 1 and dac_data = the raw sample. With st_done and the timeout in the same cycle -> st_result is emitted and timeout_err stays 0.
5. Mode 2, second adc_valid during WAIT -> overrun = 1, exactly one dac_valid for the first sample, second sample absent.
6. Reset asserted during WAIT -> outputs return to reset values in the same cycle, dac_data = 2048. After release, the first sample is processed normally.
